// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the FFT frame serializer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } state_e;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  function automatic int calc_bpw(input int word_size, input int data_length);
    return (word_size + data_length - 1) / data_length;
  endfunction

  function automatic int calc_payload(input int num_words, input int word_size,
                                      input int data_length);
    return num_words * calc_bpw(word_size, data_length);
  endfunction

  function automatic int calc_total(input int num_words, input int word_size,
                                    input int data_length, input bit send_header,
                                    input bit send_checksum);
    return calc_payload(num_words, word_size, data_length)
           + int'(send_header) + int'(send_checksum);
  endfunction

endpackage

// File: rtl/fft_byte_select.sv
// Combinational map from (snapshot, payload index) to one zero-padded byte;
// words go out word 0 first, least-significant byte first.
module fft_byte_select
  import fft_pkg::*;
#(
  parameter int NUM_WORDS   = 32,
  parameter int WORD_SIZE   = 16,
  parameter int DATA_LENGTH = 8,
  parameter int IDX_W       = 7
) (
  input  logic [NUM_WORDS*WORD_SIZE-1:0] snapshot_i,
  input  logic [IDX_W-1:0]               idx_i,
  output logic [DATA_LENGTH-1:0]         byte_o
);

  localparam int BPW     = calc_bpw(WORD_SIZE, DATA_LENGTH);
  localparam int PAYLOAD = calc_payload(NUM_WORDS, WORD_SIZE, DATA_LENGTH);

  logic [BPW*DATA_LENGTH-1:0] word_pad;
  logic [DATA_LENGTH-1:0]     byte_arr [PAYLOAD];

  always_comb begin
    word_pad = '0;
    byte_arr = '{default: '0};
    for (int k = 0; k < NUM_WORDS; k++) begin
      word_pad                 = '0;
      word_pad[WORD_SIZE-1:0]  = snapshot_i[k*WORD_SIZE +: WORD_SIZE];
      for (int b = 0; b < BPW; b++) begin
        byte_arr[k*BPW+b] = word_pad[b*DATA_LENGTH +: DATA_LENGTH];
      end
    end
    // Out-of-range indices (header/checksum slots) read back as zero.
    byte_o = '0;
    for (int p = 0; p < PAYLOAD; p++) begin
      if (idx_i == IDX_W'(p)) byte_o = byte_arr[p];
    end
  end

endmodule

// File: rtl/fft_frame_serializer.sv
// Snapshots an FFT result frame and streams it byte-by-byte to a UART
// transmitter, optionally wrapped in a header byte and a trailing checksum.
module fft_frame_serializer
  import fft_pkg::*;
#(
  parameter int                     NUM_WORDS     = 32,
  parameter int                     WORD_SIZE     = 16,
  parameter int                     DATA_LENGTH   = 8,
  parameter bit                     SEND_HEADER   = 1'b1,
  parameter logic [DATA_LENGTH-1:0] HEADER_BYTE   = DATA_LENGTH'(HEADER_BYTE_DEFAULT),
  parameter bit                     SEND_CHECKSUM = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_WORDS*WORD_SIZE-1:0] i_words,
  input  logic                           i_words_valid,
  input  logic                           i_tx_done,
  output logic                           o_tx_start,
  output logic [DATA_LENGTH-1:0]         o_tx_byte,
  output logic                           o_busy,
  output logic                           o_frame_done,
  output logic                           o_overrun
);

  localparam int TOTAL = calc_total(NUM_WORDS, WORD_SIZE, DATA_LENGTH,
                                    SEND_HEADER, SEND_CHECKSUM);
  localparam int IDXW  = $clog2(TOTAL + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TOTAL - 1);

  state_e                         state_q, state_d;
  logic [IDXW-1:0]                idx_q, idx_d;
  logic [DATA_LENGTH-1:0]         csum_q, csum_d;
  logic                           tx_start_q, tx_start_d;
  logic [DATA_LENGTH-1:0]         tx_byte_q, tx_byte_d;
  logic                           busy_q, busy_d;
  logic                           frame_done_q, frame_done_d;
  logic                           overrun_q, overrun_d;
  logic [NUM_WORDS*WORD_SIZE-1:0] snap_q;

  logic                   capture;
  logic                   is_header;
  logic                   is_csum;
  logic [IDXW-1:0]        pay_idx;
  logic [DATA_LENGTH-1:0] pay_byte;

  assign capture   = (state_q == IDLE) && i_words_valid;
  assign is_header = SEND_HEADER && (idx_q == '0);
  assign is_csum   = SEND_CHECKSUM && (idx_q == LAST_IDX);
  assign pay_idx   = idx_q - IDXW'(SEND_HEADER);

  fft_byte_select #(
    .NUM_WORDS   (NUM_WORDS),
    .WORD_SIZE   (WORD_SIZE),
    .DATA_LENGTH (DATA_LENGTH),
    .IDX_W       (IDXW)
  ) u_byte_select (
    .snapshot_i (snap_q),
    .idx_i      (pay_idx),
    .byte_o     (pay_byte)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    tx_start_d   = 1'b0;
    tx_byte_d    = tx_byte_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = i_words_valid && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (i_words_valid) begin
          idx_d   = '0;
          csum_d  = '0;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tx_start_d = 1'b1;
        if (is_header) begin
          tx_byte_d = HEADER_BYTE;
        end else if (is_csum) begin
          tx_byte_d = csum_q;
        end else begin
          tx_byte_d = pay_byte;
          csum_d    = csum_q + pay_byte;
        end
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done coinciding with our own start pulse belongs to no byte.
        if (i_tx_done && !tx_start_q) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      csum_q       <= '0;
      tx_start_q   <= 1'b0;
      tx_byte_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      tx_start_q   <= tx_start_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // NOTE: the snapshot is wide data storage and is only read after a capture,
  // so it deliberately has no reset.
  always_ff @(posedge i_clk) begin
    if (capture) snap_q <= i_words;
  end

  assign o_tx_start   = tx_start_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Self-checking bench: a default-configured serializer and a small one without
// header/checksum, both served by a behavioural UART responder.
module tb_fft_frame_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] d_words;
  logic         d_valid;
  logic [47:0]  s_words;
  logic         s_valid;
  logic         tx_done;

  logic       d_start, d_busy, d_fdone, d_ovr;
  logic [7:0] d_byte;
  logic       s_start, s_busy, s_fdone, s_ovr;
  logic [7:0] s_byte;

  bit         sel;
  logic       m_start, m_busy, m_fdone, m_ovr;
  logic [7:0] m_byte;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int unsigned words_m[32];

  int first_start_cyc, busy_gap, n_fdone, stable_err, timed_out;
  int ovr_cnt, ovr_cyc, inj_cyc;
  int ovr_at  = -1;
  int stop_at = 0;
  bit inj_issue = 1'b0;
  bit inj_same  = 1'b0;

  always #5 clk = ~clk;

  fft_frame_serializer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_words       (d_words),
    .i_words_valid (d_valid),
    .i_tx_done     (tx_done),
    .o_tx_start    (d_start),
    .o_tx_byte     (d_byte),
    .o_busy        (d_busy),
    .o_frame_done  (d_fdone),
    .o_overrun     (d_ovr)
  );

  fft_frame_serializer #(
    .NUM_WORDS     (4),
    .WORD_SIZE     (12),
    .DATA_LENGTH   (8),
    .SEND_HEADER   (1'b0),
    .HEADER_BYTE   (8'hA5),
    .SEND_CHECKSUM (1'b0)
  ) dut_s (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_words       (s_words),
    .i_words_valid (s_valid),
    .i_tx_done     (tx_done),
    .o_tx_start    (s_start),
    .o_tx_byte     (s_byte),
    .o_busy        (s_busy),
    .o_frame_done  (s_fdone),
    .o_overrun     (s_ovr)
  );

  assign m_start = sel ? s_start : d_start;
  assign m_byte  = sel ? s_byte  : d_byte;
  assign m_busy  = sel ? s_busy  : d_busy;
  assign m_fdone = sel ? s_fdone : d_fdone;
  assign m_ovr   = sel ? s_ovr   : d_ovr;

  // Reference frame: optional header, each word LS byte first (zero-padded),
  // optional modulo-256 sum of payload bytes.
  function automatic void build_exp(input int nw, input int ws, input bit hdr, input bit cs);
    int unsigned sum;
    int unsigned w;
    int          bpw;
    exp_q.delete();
    sum = 0;
    bpw = (ws + 7) / 8;
    if (hdr) exp_q.push_back(8'hA5);
    for (int k = 0; k < nw; k++) begin
      w = words_m[k] & ((32'd1 << ws) - 32'd1);
      for (int b = 0; b < bpw; b++) begin
        exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
        sum += (w >> (8 * b)) & 32'hFF;
      end
    end
    if (cs) exp_q.push_back(8'(sum));
  endfunction

  task automatic rand_words(input int nw, input int ws);
    for (int k = 0; k < 32; k++) words_m[k] = 0;
    for (int k = 0; k < nw; k++) words_m[k] = $urandom & ((32'd1 << ws) - 32'd1);
  endtask

  task automatic load_default();
    for (int k = 0; k < 32; k++) d_words[k*16 +: 16] = words_m[k][15:0];
    @(negedge clk);
    d_valid = 1'b1;
  endtask

  task automatic load_small();
    s_words = '0;
    for (int k = 0; k < 4; k++) s_words[k*12 +: 12] = words_m[k][11:0];
    @(negedge clk);
    s_valid = 1'b1;
  endtask

  // Behavioural UART_TX: answers each start with a done pulse dly cycles later
  // and records what the selected DUT did until its frame_done.
  task automatic serve(input int dly, input int max_cyc);
    int cd;
    bit prev_real;
    cd = 0; prev_real = 1'b0;
    got_q.delete();
    first_start_cyc = -1; busy_gap = 0; n_fdone = 0; stable_err = 0;
    timed_out = 1; ovr_cnt = 0; ovr_cyc = -1; inj_cyc = -1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      d_valid = 1'b0; s_valid = 1'b0; tx_done = 1'b0;
      if (m_ovr) begin ovr_cnt++; ovr_cyc = c; end
      if (m_fdone) begin n_fdone++; timed_out = 0; break; end
      if (!m_busy) busy_gap++;
      if (m_start) begin
        got_q.push_back(m_byte);
        cd = dly;
        if (first_start_cyc < 0) first_start_cyc = c;
        if (inj_same) tx_done = 1'b1;
        if (stop_at > 0 && got_q.size() == stop_at) begin timed_out = 0; break; end
        if (ovr_at >= 0 && got_q.size() == ovr_at + 1) begin
          d_valid = 1'b1; d_words = ~d_words; inj_cyc = c;
        end
      end else begin
        if (got_q.size() > 0 && m_byte !== got_q[$]) stable_err++;
        if (prev_real && inj_issue) tx_done = 1'b1;
        prev_real = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin tx_done = 1'b1; prev_real = 1'b1; end
        end
      end
    end
  endtask

  task automatic idle_watch(input int n, output int starts, output int busys);
    starts = 0; busys = 0;
    repeat (n) begin
      @(negedge clk);
      if (m_start) starts++;
      if (m_busy) busys++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; d_valid = 1'b0; s_valid = 1'b0; tx_done = 1'b0;
    d_words = '0; s_words = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({d_start, d_byte, d_busy, d_fdone, d_ovr} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_default: outputs=%h want 000", {d_start, d_byte, d_busy, d_fdone, d_ovr});
    end
    n_total++;
    if ({s_start, s_byte, s_busy, s_fdone, s_ovr} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_small: outputs=%h want 000", {s_start, s_byte, s_busy, s_fdone, s_ovr});
    end
    rst = 1'b0;
  endtask

  task automatic test_default_frame();
    int st, bz;
    sel = 1'b0;
    for (int k = 0; k < 32; k++) words_m[k] = 0;
    words_m[0] = 32'h1234;
    build_exp(32, 16, 1'b1, 1'b1);
    load_default();
    serve(100, 66 * 110 + 50);
    n_total++;
    if (timed_out != 0) begin n_bad++; $display("FAIL dflt_timeout: frame_done not seen"); end
    n_total++;
    if (got_q.size() != 66) begin n_bad++; $display("FAIL dflt_starts: got %0d want 66", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL dflt_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_total++;
    if (got_q.size() == 66 && got_q[65] !== 8'h46) begin
      n_bad++; $display("FAIL dflt_checksum: got %h want 46", got_q[65]);
    end
    n_total++;
    if (first_start_cyc != 1) begin n_bad++; $display("FAIL dflt_latency: got %0d want 1", first_start_cyc); end
    n_total++;
    if (busy_gap != 0) begin n_bad++; $display("FAIL dflt_busy_span: %0d low cycles want 0", busy_gap); end
    n_total++;
    if (stable_err != 0) begin n_bad++; $display("FAIL dflt_byte_stable: %0d changes want 0", stable_err); end
    n_total++;
    if (d_busy !== 1'b0) begin n_bad++; $display("FAIL dflt_busy_end: got %b want 0", d_busy); end
    idle_watch(8, st, bz);
    n_total++;
    if (st != 0 || bz != 0) begin
      n_bad++; $display("FAIL dflt_after: starts=%0d busy=%0d want 0 0", st, bz);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] pat [2];
    logic [7:0]  ck  [2];
    pat[0] = 16'h0101; ck[0] = 8'h40;
    pat[1] = 16'hFFFF; ck[1] = 8'hC0;
    sel = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 32; k++) words_m[k] = {16'h0, pat[p]};
      build_exp(32, 16, 1'b1, 1'b1);
      load_default();
      serve($urandom_range(1, 6), 66 * 12 + 50);
      n_total++;
      if (got_q.size() != exp_q.size() || timed_out != 0) begin
        n_bad++; $display("FAIL pat%0d_len: got %0d want %0d", p, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_total++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL pat%0d_byte[%0d]: got %h want %h", p, i, got_q[i], exp_q[i]);
        end
      end
      n_total++;
      if (got_q.size() > 0 && got_q[$] !== ck[p]) begin
        n_bad++; $display("FAIL pat%0d_checksum: got %h want %h", p, got_q[$], ck[p]);
      end
    end
  endtask

  task automatic test_small();
    logic [7:0] fixed [8];
    fixed[0] = 8'hBC; fixed[1] = 8'h0A; fixed[2] = 8'h23; fixed[3] = 8'h01;
    fixed[4] = 8'h56; fixed[5] = 8'h04; fixed[6] = 8'h89; fixed[7] = 8'h07;
    sel = 1'b1;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) begin
        for (int k = 0; k < 32; k++) words_m[k] = 0;
        words_m[0] = 32'hABC; words_m[1] = 32'h123; words_m[2] = 32'h456; words_m[3] = 32'h789;
      end else begin
        rand_words(4, 12);
      end
      build_exp(4, 12, 1'b0, 1'b0);
      load_small();
      serve($urandom_range(1, 5), 200);
      n_total++;
      if (got_q.size() != 8 || timed_out != 0) begin
        n_bad++; $display("FAIL small%0d_starts: got %0d want 8", r, got_q.size());
      end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
        n_total++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL small%0d_byte[%0d]: got %h want %h", r, i, got_q[i], exp_q[i]);
        end
        if (r == 0) begin
          n_total++;
          if (got_q[i] !== fixed[i]) begin
            n_bad++; $display("FAIL small_fixed[%0d]: got %h want %h", i, got_q[i], fixed[i]);
          end
        end
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_overrun();
    sel = 1'b0;
    rand_words(32, 16);
    build_exp(32, 16, 1'b1, 1'b1);
    load_default();
    ovr_at = 10;
    serve($urandom_range(2, 5), 66 * 10 + 50);
    ovr_at = -1;
    n_total++;
    if (ovr_cnt != 1) begin n_bad++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt); end
    n_total++;
    if (ovr_cyc != inj_cyc + 1) begin
      n_bad++; $display("FAIL ovr_timing: pulse at %0d want %0d", ovr_cyc, inj_cyc + 1);
    end
    n_total++;
    if (got_q.size() != exp_q.size() || timed_out != 0) begin
      n_bad++; $display("FAIL ovr_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL ovr_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    rand_words(32, 16);
    load_default();
    stop_at = 6;
    serve(4, 200);
    stop_at = 0;
    rst = 1'b1; tx_done = 1'b0;
    @(negedge clk);
    n_total++;
    if ({d_start, d_byte, d_busy, d_fdone, d_ovr} !== 12'h0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %h want 000", {d_start, d_byte, d_busy, d_fdone, d_ovr});
    end
    rst = 1'b0;
    rand_words(32, 16);
    build_exp(32, 16, 1'b1, 1'b1);
    load_default();
    serve($urandom_range(1, 4), 66 * 8 + 50);
    n_total++;
    if (got_q.size() != exp_q.size() || timed_out != 0) begin
      n_bad++; $display("FAIL rstmid_len: got %0d want %0d", got_q.size(), exp_q.size());
    end
    n_total++;
    if (got_q.size() > 0 && got_q[0] !== 8'hA5) begin
      n_bad++; $display("FAIL rstmid_header: got %h want a5", got_q[0]);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL rstmid_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_done_inject();
    int st, bz;
    sel = 1'b0;
    st = 0; bz = 0;
    repeat (4) begin
      @(negedge clk);
      tx_done = ~tx_done;
      if (d_start) st++;
      if (d_busy) bz++;
    end
    @(negedge clk);
    tx_done = 1'b0;
    n_total++;
    if (st != 0 || bz != 0) begin
      n_bad++; $display("FAIL inj_idle: starts=%0d busy=%0d want 0 0", st, bz);
    end
    rand_words(32, 16);
    build_exp(32, 16, 1'b1, 1'b1);
    load_default();
    inj_issue = 1'b1; inj_same = 1'b1;
    serve($urandom_range(2, 5), 66 * 10 + 50);
    inj_issue = 1'b0; inj_same = 1'b0;
    n_total++;
    if (got_q.size() != 66 || timed_out != 0) begin
      n_bad++; $display("FAIL inj_starts: got %0d want 66", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL inj_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rand_words(32, 16);
      build_exp(32, 16, 1'b1, 1'b1);
      for (int k = 0; k < 32; k++) d_words[k*16 +: 16] = words_m[k][15:0];
      d_valid = 1'b1;
      serve($urandom_range(1, 4), 66 * 8 + 50);
      n_total++;
      if (got_q.size() != exp_q.size() || timed_out != 0 || n_fdone != 1) begin
        n_bad++;
        $display("FAIL b2b%0d_len: got %0d want %0d (frame_done %0d)", r, got_q.size(), exp_q.size(), n_fdone);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_total++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL b2b%0d_byte[%0d]: got %h want %h", r, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_patterns();
    test_small();
    test_overrun();
    test_reset_mid();
    test_done_inject();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
